// File: rtl/twi_uart_tx.sv
// UART transmitter (8N1/8N2, LSB first) feeding the TWI monitor's host link.
// Paces the frame presenter through tx_busy and drives the serial output pin.
module twi_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_serial,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             stop_cnt;
  logic             bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // outputs are set on the edge that enters the new state, keeping them glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      stop_cnt  <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          stop_cnt <= 1'b0;
          if (tx_start) begin
            shift_reg <= tx_data;
            state     <= START;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            state     <= DATA;
            tx_serial <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx   <= '0;
              stop_cnt  <= 1'b0;
              state     <= STOP;
              tx_serial <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              // The bit about to move into shift_reg[0] goes on the line now.
              tx_serial <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          tx_serial <= 1'b1;
          tx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
